conv1_pool_stage: RTL and testbench
===================================

# conv1_pool_stage

Streaming post-processing stage directly downstream of the conv1 GEMM engine. Consumes the conv1 int32 output feature map (64x56x56, channel-major raster), requantizes each value to int16 with rounding and saturation, applies ReLU, and performs 3x3 / stride-2 / pad-1 max pooling. It produces the 64x28x28 int16 map that feeds the first residual stage. It uses one pixel-per-cycle valid/ready streams on both sides and holds only two half-row buffers.

## Interface
- `CH`, default 64: channels per frame.
- `H_IN`, default 56: input rows. Must be even.
- `W_IN`, default 56: input columns. Must be even.
- `SHIFT`, default 8: requantization right-shift. Range 1..31.
- `clk` input 1: the single clock for the block. One clock; reset is asynchronous and active-high.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that arms a frame. Honoured only in IDLE.
- `s_valid` input 1: input beat valid.
- `s_ready` output 1: block can accept an input beat.
- `s_data` input 32: signed conv1 accumulator value.
- `m_valid` output 1: pooled output valid.
- `m_ready` input 1: downstream accepts the output.
- `m_data` output 16: signed pooled value. Always ≥ 0.
- `m_ch` output 6: channel index of `m_data`.
- `m_row` output 5: output row index.
- `m_col` output 5: output column index.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle pulse after the last output is accepted.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE → RUN on `start`. All counters clear.
  - RUN → DRAIN on acceptance of input beat (CH-1, H_IN-1, W_IN-1).
  - DRAIN → DONE when the final output handshake completes.
  - DONE → IDLE after one cycle, with `done`=1 during that cycle.
- Input counters `c`, `r` and `x` advance on each accepted beat (`s_valid && s_ready`) in raster order: x fastest, then r, then c.
- Requantization: `q = sat16((s_data + 2^(SHIFT-1)) >>> SHIFT)`.
  - The sum is computed in 33 bits.
  - `sat16` clamps to [-32768, 32767].
- ReLU: `v = max(q, 0)`. Because every `v` is ≥ 0, padding is represented by 0.
- Horizontal max:
  - Registers `p1` and `p2` hold `v` at x-1 and x-2. Both are forced to 0 at x=0 (left pad).
  - On odd x, `h = max(p1, p2, v)` covers columns 2ox-1..2ox+1, where ox = x>>1.
- Buffers `carry[W_IN/2]` and `acc[W_IN/2]` are int16 each. Behaviour on odd x:
  - **Even r, r=2oy:** `acc[ox] = max(r==0 ? 0 : carry[ox], h)`.
  - **Odd r:** emit `max(acc[ox], h)` with tags (c, r>>1, ox), then write `carry[ox] = h`.
- Channel boundary: the r==0 rule masks stale `carry` contents, so no buffer clearing is required.
- Outputs per frame: CH·(H_IN/2)·(W_IN/2), i.e. 50176 at defaults.

## Timing
- Reset values:
  - `s_ready`, `m_valid`, `busy` and `done` are 0.
  - `m_data`, `m_ch`, `m_row` and `m_col` are 0.
  - FSM is in IDLE and all counters and pixel registers are 0.
  - Buffer contents are don't-care.
- `s_ready = (state==RUN) && (!m_valid || m_ready)`. It is combinational and identical on every beat, including non-emitting beats.
- Latency: an emitting input beat accepted at edge N gives `m_valid`=1 after edge N.
- Output register:
  - It holds its value while `m_valid && !m_ready`.
  - It is cleared at the edge where it is accepted, unless a new emitting beat is accepted at that same edge, in which case it reloads with the new value.
- Sustained throughput is 1 input beat per cycle when `m_ready`=1.
- `start` outside IDLE is ignored.
- `s_valid` outside RUN is ignored, because `s_ready`=0.
- An asserted `rst` mid-frame aborts immediately. The block returns to IDLE and no `done` pulse is produced.
- `done` and a new `start` in the same cycle: `start` is ignored. It is accepted one cycle later, in IDLE.

## Configuration
- `CONV1_POOL_SATCNT_EN` defined:
  - Adds output `sat_cnt` (32 bits, reset 0).
  - The counter clears on an accepted `start` and increments by 1 on each accepted beat whose requantization clamped in either direction.
  - The counter saturates at its maximum value and holds its value after DONE.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Single-channel ramp.** Configuration: CH=1, H_IN=W_IN=4, SHIFT=1, s_data = 2·(4r+x). Required outputs, in order: 5, 7, 13, 15, with tags (0,0,0), (0,0,1), (0,1,0), (0,1,1), followed by one `done` pulse.
- **Rounding and saturation.** SHIFT=8. Required results:
  - s_data=383 → q=1.
  - s_data=384 → q=2.
  - s_data=0x7FFFFFFF → q=32767, and `sat_cnt` increments.
  - s_data=-1000 → ReLU gives 0.
- **Pad and ReLU.** An all-negative frame gives all outputs 0. A frame that is all-negative except a single 100·256 at (r=0, x=0), with SHIFT=8, gives an output of 100 at (0,0,0) only.
- **Backpressure.** Defaults with random input; `m_ready` toggles with a 30% duty cycle. Required response:
  - The 50176 outputs match the golden model bit-exact.
  - No output is dropped or duplicated.
  - `s_ready` stays low whenever `m_valid && !m_ready`.
- **Full-rate throughput.** Defaults with `s_valid`=`m_ready`=1. Required response:
  - The frame completes in 200704 accepted beats, with `done` 2 cycles after the last input beat.
  - `busy` is high for exactly that span.
- **Mid-frame reset.** Assert `rst` after 1000 beats. Required response:
  - All outputs return to their reset values, with no `done` pulse.
  - A subsequent `start` and full frame pass against the golden model.

Source files
------------

// File: rtl/conv1_pool_stage_if.sv
// Stream bundle for conv1_pool_stage: int32 input beats in, tagged int16 pooled values out.
// The slave modport is the pooling stage. The master modport is whoever feeds and drains it.
interface conv1_pool_stage_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [5:0]  m_ch;
    logic [4:0]  m_row;
    logic [4:0]  m_col;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ch, m_row, m_col
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ch, m_row, m_col
    );
endinterface

// File: rtl/conv1_pool_stage.sv
// conv1 post-processing: requantize int32->int16 (round, saturate), ReLU, 3x3/s2/pad1 max pool.
// Optional saturation counter port sat_cnt is enabled by defining CONV1_POOL_SATCNT_EN.
module conv1_pool_stage #(
    parameter int CH    = 64,
    parameter int H_IN  = 56,
    parameter int W_IN  = 56,
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    conv1_pool_stage_if.slave bus,
    output logic              busy,
    output logic              done
`ifdef CONV1_POOL_SATCNT_EN
    ,
    output logic [31:0]       sat_cnt
`endif
);
    localparam int XW   = $clog2(W_IN);
    localparam int RW   = $clog2(H_IN);
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int OW   = XW - 1;
    localparam int HALF = W_IN / 2;
    localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_reg;
    logic [XW-1:0] x_reg;
    logic [RW-1:0] r_reg;
    logic [CW-1:0] c_reg;
    logic [15:0]   p1_reg;
    logic [15:0]   p2_reg;
    logic          m_valid_reg;
    logic [15:0]   m_data_reg;
    logic [5:0]    m_ch_reg;
    logic [4:0]    m_row_reg;
    logic [4:0]    m_col_reg;

    logic [15:0]   carry_mem [HALF];
    logic [15:0]   acc_mem   [HALF];

    logic                 s_ready_w;
    logic                 accept;
    logic                 emit;
    logic                 last_x;
    logic                 last_r;
    logic                 last_c;
    logic signed [32:0]   sum_w;
    logic signed [32:0]   shr_w;
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic [15:0]          q;
    logic [15:0]          v;
    logic [15:0]          h;
    logic [15:0]          carry_eff;
    logic [15:0]          acc_next;
    logic [15:0]          pool;
    logic [OW-1:0]        ox;

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    assign s_ready_w = (state_reg == RUN) && (!m_valid_reg || bus.m_ready);
    assign accept    = bus.s_valid && s_ready_w;
    assign last_x    = (x_reg == XW'(W_IN - 1));
    assign last_r    = (r_reg == RW'(H_IN - 1));
    assign last_c    = (c_reg == CW'(CH - 1));
    assign emit      = accept && x_reg[0] && r_reg[0];
    assign ox        = x_reg[XW-1:1];

    always_comb begin
        sum_w    = $signed({bus.s_data[31], bus.s_data}) + RND;
        shr_w    = sum_w >>> SHIFT;
        clamp_hi = (shr_w > 33'sd32767);
        clamp_lo = (shr_w < -33'sd32768);
        if (clamp_hi)
            q = 16'h7FFF;
        else if (clamp_lo)
            q = 16'h8000;
        else
            q = shr_w[15:0];
        v = q[15] ? 16'd0 : q;
        // On odd x, p1/p2 hold columns x-1 and x-2 (p2 already zeroed for the left pad).
        h         = max16(max16(p1_reg, p2_reg), v);
        // Row 0 of every channel ignores carry, which hides the previous channel's last row.
        carry_eff = (r_reg == '0) ? 16'd0 : carry_mem[ox];
        acc_next  = max16(carry_eff, h);
        pool      = max16(acc_mem[ox], h);
    end

    // Half-row buffers: even rows build acc, odd rows emit and leave their h as next carry.
    always_ff @(posedge clk) begin
        if (accept && x_reg[0]) begin
            if (r_reg[0])
                carry_mem[ox] <= h;
            else
                acc_mem[ox] <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            x_reg       <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            p1_reg      <= '0;
            p2_reg      <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_ch_reg    <= '0;
            m_row_reg   <= '0;
            m_col_reg   <= '0;
        end else begin
            if (emit) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= pool;
                m_ch_reg    <= 6'(c_reg);
                m_row_reg   <= 5'(r_reg >> 1);
                m_col_reg   <= 5'(ox);
            end else if (m_valid_reg && bus.m_ready) begin
                m_valid_reg <= 1'b0;
                m_data_reg  <= '0;
                m_ch_reg    <= '0;
                m_row_reg   <= '0;
                m_col_reg   <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        x_reg     <= '0;
                        r_reg     <= '0;
                        c_reg     <= '0;
                        p1_reg    <= '0;
                        p2_reg    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        p1_reg <= v;
                        p2_reg <= (x_reg == '0) ? 16'd0 : p1_reg;
                        if (last_x) begin
                            x_reg <= '0;
                            if (last_r) begin
                                r_reg <= '0;
                                c_reg <= c_reg + 1'b1;
                                if (last_c)
                                    state_reg <= DRAIN;
                            end else begin
                                r_reg <= r_reg + 1'b1;
                            end
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (m_valid_reg && bus.m_ready)
                        state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef CONV1_POOL_SATCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (state_reg == IDLE && start)
            sat_cnt <= '0;
        else if (accept && (clamp_hi || clamp_lo) && (sat_cnt != 32'hFFFF_FFFF))
            sat_cnt <= sat_cnt + 32'd1;
    end
`endif

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_data  = m_data_reg;
    assign bus.m_ch    = m_ch_reg;
    assign bus.m_row   = m_row_reg;
    assign bus.m_col   = m_col_reg;
    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
endmodule

// File: tb/tb_conv1_pool_stage.sv
// Directed bench for conv1_pool_stage on a 2x4x4 frame with SHIFT=8.
// Expected pooled values are hand-derived from the 3x3/s2/pad1 window of each output.
module tb_conv1_pool_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef CONV1_POOL_SATCNT_EN
    logic [31:0] sat_cnt;
`endif

    int total = 0;
    int passes = 0;
    int fails = 0;

    int          din [32];
    logic [15:0] exp_d [8];
    logic [15:0] got_d [16];
    logic [15:0] got_t [16];
    int out_n, done_cnt, idx, first_in, last_in, done_iter, bp_viol;
    logic busy_last, busy_done;

    always #5 clk = ~clk;

    conv1_pool_stage_if bus ();

    conv1_pool_stage #(
        .CH(2), .H_IN(4), .W_IN(4), .SHIFT(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done)
`ifdef CONV1_POOL_SATCNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // mode 0: full rate, 1: random valid / ~30% ready, 2: downstream stalled
    task automatic run_frame(input int mode, input int abort_at);
        out_n = 0; done_cnt = 0; idx = 0; first_in = -1; last_in = -1;
        done_iter = -1; bp_viol = 0; busy_last = 1'b0; busy_done = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                bus.s_valid = 1'b0;
                break;
            end
            bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
            bus.s_valid = (idx < 32) && (mode != 1 || $urandom_range(0, 3) != 0);
            bus.s_data  = din[(idx < 32) ? idx : 0];
            #1;
            if (bus.m_valid && !bus.m_ready && bus.s_ready) bp_viol++;
            if (bus.m_valid && bus.m_ready && out_n < 16) begin
                got_d[out_n] = bus.m_data;
                got_t[out_n] = {bus.m_ch, bus.m_row, bus.m_col};
                $display("out %0d: ch=%0d row=%0d col=%0d data=%0d", out_n, bus.m_ch, bus.m_row, bus.m_col, bus.m_data);
                out_n++;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (first_in < 0) first_in = k;
                last_in = k;
                busy_last = busy;
                idx++;
            end
            if (done) begin
                done_cnt++;
                if (done_iter < 0) begin
                    done_iter = k;
                    busy_done = busy;
                end
            end
            if (done_iter >= 0 && k >= done_iter + 3) break;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic check_frame(input string name, input int mode);
        check({name, " out_count"}, out_n, 8);
        check({name, " done_pulses"}, done_cnt, 1);
        check({name, " sready_bp"}, bp_viol, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s data[%0d]", name, i), got_d[i], exp_d[i]);
            check($sformatf("%s tag[%0d]", name, i), got_t[i], {6'(i >> 2), 5'((i >> 1) & 1), 5'(i & 1)});
        end
        if (mode == 0) begin
            check({name, " beat_span"}, last_in - first_in, 31);
            check({name, " done_lat"}, done_iter - last_in, 2);
            check({name, " busy_run"}, busy_last, 1);
            check({name, " busy_done"}, busy_done, 0);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) din[i] = 256 * i;
        for (int i = 16; i < 32; i++) din[i] = 256;
        exp_d[0] = 5;  exp_d[1] = 7;  exp_d[2] = 13; exp_d[3] = 15;
        exp_d[4] = 1;  exp_d[5] = 1;  exp_d[6] = 1;  exp_d[7] = 1;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst s_ready", bus.s_ready, 0);
        check("rst m_valid", bus.m_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst m_data", bus.m_data, 0);
        check("rst tags", {bus.m_ch, bus.m_row, bus.m_col}, 0);
        rst = 1'b0;

        // ramp on ch0, constant 1 on ch1 (stale carry from ch0 must not leak)
        load_ramp();
        run_frame(0, -1);
        check_frame("ramp", 0);

        // rounding, saturation, ReLU, single-pixel pad probe
        for (int i = 0; i < 32; i++) din[i] = -5000000;
        din[0]  = 383;
        din[3]  = 384;
        din[12] = 2147483647;
        din[15] = -1000;
        din[16] = 25600;
        din[26] = -2147483647 - 1;
        exp_d[0] = 1;   exp_d[1] = 2; exp_d[2] = 32767; exp_d[3] = 0;
        exp_d[4] = 100; exp_d[5] = 0; exp_d[6] = 0;     exp_d[7] = 0;
        run_frame(0, -1);
        check_frame("round", 0);
`ifdef CONV1_POOL_SATCNT_EN
        check("sat_cnt round", sat_cnt, 2);
`endif

        // ramp again with random valid gaps and backpressure
        load_ramp();
        run_frame(1, -1);
        check_frame("backpr", 1);
`ifdef CONV1_POOL_SATCNT_EN
        check("sat_cnt backpr", sat_cnt, 0);
`endif

        // all-negative frame
        for (int i = 0; i < 32; i++) din[i] = -300;
        for (int i = 0; i < 8; i++) exp_d[i] = 0;
        run_frame(0, -1);
        check_frame("neg", 0);

        // stall downstream so the first output is held, then abort with reset
        load_ramp();
        run_frame(2, 6);
        check("stall beats", idx, 6);
        check("stall m_valid", bus.m_valid, 1);
        check("stall m_data", bus.m_data, 5);
        check("stall s_ready", bus.s_ready, 0);
        check("stall busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort s_ready", bus.s_ready, 0);
        check("abort m_valid", bus.m_valid, 0);
        check("abort busy", busy, 0);
        check("abort m_data", bus.m_data, 0);
        check("abort tags", {bus.m_ch, bus.m_row, bus.m_col}, 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);

        run_frame(0, -1);
        check_frame("after_rst", 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
